// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipeline_stall_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  localparam logic [4:0] REG_ZERO       = 5'd0;
  localparam int         MD_LATENCY_DEF = 4;
endpackage

// File: rtl/pipeline_stall_ctrl_load_use_detect.sv
// Load-use hazard compare: a load in EX writes a register the ID instruction reads.
module load_use_detect
  import pipeline_stall_ctrl_pkg::*;
(
  input  logic [4:0] IFID_regRs,
  input  logic [4:0] IFID_regRt,
  input  logic [4:0] IDEXE_regRd,
  input  logic       IDEXE_memRead,
  output logic       lu_o
);
  assign lu_o = IDEXE_memRead && (IDEXE_regRd != REG_ZERO) &&
                ((IDEXE_regRd == IFID_regRs) || (IDEXE_regRd == IFID_regRt));
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer: load-use bubbles, taken-branch flushes and
// multi-cycle mul/div occupancy of EX, plus a saturating stall-cycle counter.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEF,
  parameter int CNT_W      = 4,
  parameter int PERF_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [4:0]        IFID_regRs,
  input  logic [4:0]        IFID_regRt,
  input  logic [4:0]        IDEXE_regRd,
  input  logic              IDEXE_memRead,
  input  logic              IDEXE_mdStart,
  input  logic              EX_branchTaken,
  output logic              PC_write,
  output logic              IFID_write,
  output logic              IFID_flush,
  output logic              IDEXE_bubble,
  output logic              IDEXE_hold,
  output logic              EXMEM_bubble,
  output logic              md_busy,
  output logic [PERF_W-1:0] stall_cnt
);
  // MD_BUSY runs md_cnt down to zero, so it is loaded with the busy length minus one.
  localparam logic [CNT_W-1:0] MD_START = CNT_W'((MD_LATENCY >= 3) ? (MD_LATENCY - 3) : 0);

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  md_cnt_q, md_cnt_d;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
  logic              lu;

  load_use_detect u_lu (
    .IFID_regRs    (IFID_regRs),
    .IFID_regRt    (IFID_regRt),
    .IDEXE_regRd   (IDEXE_regRd),
    .IDEXE_memRead (IDEXE_memRead),
    .lu_o          (lu)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    md_cnt_d     = md_cnt_q;
    PC_write     = 1'b1;
    IFID_write   = 1'b1;
    IFID_flush   = 1'b0;
    IDEXE_bubble = 1'b0;
    IDEXE_hold   = 1'b0;
    EXMEM_bubble = 1'b0;
    md_busy      = 1'b0;
    if (rst_i) begin
      case (state_q)
        IDLE: begin
          if (IDEXE_mdStart) begin
            PC_write     = 1'b0;
            IFID_write   = 1'b0;
            IDEXE_hold   = 1'b1;
            EXMEM_bubble = 1'b1;
            md_busy      = 1'b1;
            if (MD_LATENCY == 2) begin
              state_d = MD_DONE;
            end else begin
              md_cnt_d = MD_START;
              state_d  = MD_BUSY;
            end
          end else if (EX_branchTaken) begin
            // The ID instruction is squashed, so a load-use match on it is moot.
            IFID_flush   = 1'b1;
            IDEXE_bubble = 1'b1;
          end else if (lu) begin
            PC_write     = 1'b0;
            IFID_write   = 1'b0;
            IDEXE_bubble = 1'b1;
          end
        end
        MD_BUSY: begin
          PC_write     = 1'b0;
          IFID_write   = 1'b0;
          IDEXE_hold   = 1'b1;
          EXMEM_bubble = 1'b1;
          md_busy      = 1'b1;
          if (md_cnt_q == '0) state_d = MD_DONE;
          else                md_cnt_d = md_cnt_q - 1'b1;
        end
        MD_DONE: begin
          // Final EX cycle; mdStart is still asserted by the same instruction.
          md_busy = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign stall_cnt_d = (!PC_write && (stall_cnt_q != {PERF_W{1'b1}})) ? stall_cnt_q + 1'b1
                                                                       : stall_cnt_q;
  assign stall_cnt   = stall_cnt_q;
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: default, MD_LATENCY=2 and PERF_W=4 instances.
module tb_pipeline_stall_ctrl;
  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [4:0] IFID_regRs, IFID_regRt, IDEXE_regRd;
  logic       IDEXE_memRead, IDEXE_mdStart, EX_branchTaken;

  logic        pc, ifid, fl, bub, hold, exb, busy;
  logic [15:0] cnt;
  logic        p2_pc, p2_ifid, p2_fl, p2_bub, p2_hold, p2_exb, p2_busy;
  logic [15:0] p2_cnt;
  logic        p4_pc, p4_ifid, p4_fl, p4_bub, p4_hold, p4_exb, p4_busy;
  logic [3:0]  p4_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  pipeline_stall_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .IFID_regRs(IFID_regRs), .IFID_regRt(IFID_regRt),
    .IDEXE_regRd(IDEXE_regRd), .IDEXE_memRead(IDEXE_memRead), .IDEXE_mdStart(IDEXE_mdStart),
    .EX_branchTaken(EX_branchTaken), .PC_write(pc), .IFID_write(ifid), .IFID_flush(fl),
    .IDEXE_bubble(bub), .IDEXE_hold(hold), .EXMEM_bubble(exb), .md_busy(busy), .stall_cnt(cnt));

  pipeline_stall_ctrl #(.MD_LATENCY(2)) dut2 (
    .clk_i(clk_i), .rst_i(rst_i), .IFID_regRs(IFID_regRs), .IFID_regRt(IFID_regRt),
    .IDEXE_regRd(IDEXE_regRd), .IDEXE_memRead(IDEXE_memRead), .IDEXE_mdStart(IDEXE_mdStart),
    .EX_branchTaken(EX_branchTaken), .PC_write(p2_pc), .IFID_write(p2_ifid), .IFID_flush(p2_fl),
    .IDEXE_bubble(p2_bub), .IDEXE_hold(p2_hold), .EXMEM_bubble(p2_exb), .md_busy(p2_busy),
    .stall_cnt(p2_cnt));

  pipeline_stall_ctrl #(.PERF_W(4)) dut4 (
    .clk_i(clk_i), .rst_i(rst_i), .IFID_regRs(IFID_regRs), .IFID_regRt(IFID_regRt),
    .IDEXE_regRd(IDEXE_regRd), .IDEXE_memRead(IDEXE_memRead), .IDEXE_mdStart(IDEXE_mdStart),
    .EX_branchTaken(EX_branchTaken), .PC_write(p4_pc), .IFID_write(p4_ifid), .IFID_flush(p4_fl),
    .IDEXE_bubble(p4_bub), .IDEXE_hold(p4_hold), .EXMEM_bubble(p4_exb), .md_busy(p4_busy),
    .stall_cnt(p4_cnt));

  typedef struct {
    logic [4:0] rs, rt, rd;
    logic       mr, br;
    logic       e_pc, e_ifid, e_fl, e_bub;
    int         e_cnt;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic idle_in();
    IFID_regRs = 5'd0; IFID_regRt = 5'd0; IDEXE_regRd = 5'd0;
    IDEXE_memRead = 1'b0; IDEXE_mdStart = 1'b0; EX_branchTaken = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b0; idle_in();
    tick(); tick();
    rst_i = 1'b1;
  endtask

  initial begin
    tbl[0] = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    tbl[1] = '{5'd3,  5'd8,  5'd8,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1};
    tbl[2] = '{5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1};
    tbl[3] = '{5'd9,  5'd2,  5'd9,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2};
    tbl[4] = '{5'd9,  5'd2,  5'd9,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2};
    tbl[5] = '{5'd3,  5'd4,  5'd9,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2};
    tbl[6] = '{5'd1,  5'd8,  5'd8,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2};
    tbl[7] = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2};
    tbl[8] = '{5'd31, 5'd31, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3};

    // Reset held with mdStart asserted: outputs forced to defaults.
    idle_in(); rst_i = 1'b0; IDEXE_mdStart = 1'b1;
    @(negedge clk_i);
    chk("rst_pc", pc, 1); chk("rst_ifid", ifid, 1); chk("rst_busy", busy, 0);
    tick();
    chk("rst_cnt", cnt, 0);
    @(negedge clk_i);
    chk("rst_busy2", busy, 0); chk("rst_hold", hold, 0);
    tick();
    chk("rst_cnt2", cnt, 0);

    // Release into a 4-cycle mul/div; branch and load-use must be ignored throughout.
    rst_i = 1'b1; EX_branchTaken = 1'b1;
    IDEXE_memRead = 1'b1; IDEXE_regRd = 5'd8; IFID_regRt = 5'd8;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      chk($sformatf("md_pc%0d", c), pc, (c < 3) ? 0 : 1);
      chk($sformatf("md_ifid%0d", c), ifid, (c < 3) ? 0 : 1);
      chk($sformatf("md_busy%0d", c), busy, 1);
      chk($sformatf("md_hold%0d", c), hold, (c < 3) ? 1 : 0);
      chk($sformatf("md_exb%0d", c), exb, (c < 3) ? 1 : 0);
      chk($sformatf("md_fl%0d", c), fl, 0);
      chk($sformatf("md_bub%0d", c), bub, 0);
      chk($sformatf("md2_pc%0d", c), p2_pc, (c == 0 || c == 2) ? 0 : 1);
      chk($sformatf("md2_busy%0d", c), p2_busy, 1);
      tick();
    end
    chk("md_cnt", cnt, 3); chk("md_cnt_p4", p4_cnt, 3); chk("md2_cnt", p2_cnt, 2);
    idle_in();
    @(negedge clk_i);
    chk("md_after_busy", busy, 0); chk("md_after_pc", pc, 1);
    chk("md2_after_busy", p2_busy, 0);

    // Back-to-back mul/div: mdStart held 8 cycles.
    do_reset();
    IDEXE_mdStart = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_i);
      chk($sformatf("b2b_pc%0d", c), pc, (c % 4 == 3) ? 1 : 0);
      chk($sformatf("b2b_busy%0d", c), busy, 1);
      tick();
    end
    chk("b2b_cnt", cnt, 6); chk("b2b_cnt2", p2_cnt, 4);
    idle_in();

    // Table of single-cycle IDLE vectors.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      IFID_regRs = tbl[i].rs; IFID_regRt = tbl[i].rt; IDEXE_regRd = tbl[i].rd;
      IDEXE_memRead = tbl[i].mr; EX_branchTaken = tbl[i].br; IDEXE_mdStart = 1'b0;
      @(negedge clk_i);
      chk($sformatf("v%0d_pc", i), pc, tbl[i].e_pc);
      chk($sformatf("v%0d_ifid", i), ifid, tbl[i].e_ifid);
      chk($sformatf("v%0d_flush", i), fl, tbl[i].e_fl);
      chk($sformatf("v%0d_bubble", i), bub, tbl[i].e_bub);
      chk($sformatf("v%0d_hold", i), hold, 0);
      chk($sformatf("v%0d_exb", i), exb, 0);
      chk($sformatf("v%0d_busy", i), busy, 0);
      tick();
      chk($sformatf("v%0d_cnt", i), cnt, tbl[i].e_cnt);
    end
    idle_in();

    // Saturation: 20 load-use stalls on the 4-bit counter.
    do_reset();
    IDEXE_memRead = 1'b1; IDEXE_regRd = 5'd8; IFID_regRt = 5'd8;
    for (int c = 0; c < 20; c++) tick();
    chk("sat_p4", p4_cnt, 15); chk("sat_wide", cnt, 20);
    idle_in();
    tick();
    chk("sat_p4_hold", p4_cnt, 15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
